// File: rtl/rename_table_ckpt.sv
// WAY-wide arch->RRF rename map with busy bits, tag-qualified commit release
// and a FIFO of branch snapshots used for misprediction recovery.
module rename_table_ckpt_chk #(
  parameter int CKPT_SEL = 2
) (
  input logic                clk,
  input logic                reset,
  input logic                restore_i,
  input logic [CKPT_SEL-1:0] restore_id_i,
  input logic [CKPT_SEL:0]   head_i,
  input logic [CKPT_SEL:0]   tail_i
);
  logic [CKPT_SEL-1:0] rel_s;
  logic [CKPT_SEL:0]   count_s;

  assign rel_s   = restore_id_i - head_i[CKPT_SEL-1:0];
  assign count_s = tail_i - head_i;

  // A restore must name a slot that is currently live
  restore_live_a: assert property (@(posedge clk) disable iff (!reset)
    restore_i |-> ({1'b0, rel_s} < count_s));
endmodule

module rename_table_ckpt #(
  parameter int REG_NUM  = 32,
  parameter int REG_SEL  = 5,
  parameter int RRF_SEL  = 6,
  parameter int WAY      = 2,
  parameter int CKPT_NUM = 4,
  parameter int CKPT_SEL = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WAY*2*REG_SEL-1:0] rs_i,
  output logic [WAY*2*RRF_SEL-1:0] rs_renamed_o,
  output logic [WAY*2-1:0]         rs_busy_o,
  input  logic [WAY-1:0]           settag_we_i,
  input  logic [WAY*REG_SEL-1:0]   settag_addr_i,
  input  logic [WAY*RRF_SEL-1:0]   settag_tag_i,
  input  logic [WAY-1:0]           com_we_i,
  input  logic [WAY*REG_SEL-1:0]   com_dst_i,
  input  logic [WAY*RRF_SEL-1:0]   com_renamed_i,
  input  logic                     ckpt_take_i,
  output logic [CKPT_SEL-1:0]      ckpt_id_o,
  output logic                     ckpt_full_o,
  output logic                     ckpt_empty_o,
  input  logic                     ckpt_release_i,
  input  logic                     restore_i,
  input  logic [CKPT_SEL-1:0]      restore_id_i
);
  localparam int PTR_W = CKPT_SEL + 1;

  logic [REG_NUM-1:0][RRF_SEL-1:0]               map_q, map_d;
  logic [REG_NUM-1:0]                            busy_q, busy_d;
  logic [CKPT_NUM-1:0][REG_NUM-1:0][RRF_SEL-1:0] snap_map_q, snap_map_d;
  logic [CKPT_NUM-1:0][REG_NUM-1:0]              snap_busy_q, snap_busy_d;
  logic [PTR_W-1:0]                              head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]                              count_s;
  logic [CKPT_SEL-1:0]                           rel_s;
  logic                                          take_s, release_s;

  assign count_s      = tail_q - head_q;
  assign ckpt_full_o  = (count_s == PTR_W'(CKPT_NUM));
  assign ckpt_empty_o = (tail_q == head_q);
  assign ckpt_id_o    = tail_q[CKPT_SEL-1:0];
  assign rel_s        = restore_id_i - head_q[CKPT_SEL-1:0];
  assign take_s       = ckpt_take_i & ~ckpt_full_o & ~restore_i;
  assign release_s    = ckpt_release_i & ~ckpt_empty_o;

  // Source lookup from registered state only; x0 is hardwired not-busy
  always_comb begin
    rs_renamed_o = '0;
    rs_busy_o    = '0;
    for (int s = 0; s < 2*WAY; s++) begin
      if (rs_i[s*REG_SEL +: REG_SEL] == '0) begin
        rs_busy_o[s]                       = 1'b0;
        rs_renamed_o[s*RRF_SEL +: RRF_SEL] = '0;
      end else if (busy_q[rs_i[s*REG_SEL +: REG_SEL]]) begin
        rs_busy_o[s]                       = 1'b1;
        rs_renamed_o[s*RRF_SEL +: RRF_SEL] = map_q[rs_i[s*REG_SEL +: REG_SEL]];
      end else begin
        rs_busy_o[s]                       = 1'b0;
        rs_renamed_o[s*RRF_SEL +: RRF_SEL] = RRF_SEL'(rs_i[s*REG_SEL +: REG_SEL]);
      end
    end
  end

  // Next state: restore load, then commit clears, then settag, then take/pointers
  always_comb begin
    snap_map_d  = snap_map_q;
    snap_busy_d = snap_busy_q;
    if (restore_i) begin
      map_d  = snap_map_q[restore_id_i];
      busy_d = snap_busy_q[restore_id_i];
    end else begin
      map_d  = map_q;
      busy_d = busy_q;
    end

    // Commit clears apply to every slot so a later restore cannot revive a retired tag
    for (int w = 0; w < WAY; w++) begin
      busy_d[com_dst_i[w*REG_SEL +: REG_SEL]] = busy_d[com_dst_i[w*REG_SEL +: REG_SEL]] &
        ~(com_we_i[w] && (com_dst_i[w*REG_SEL +: REG_SEL] != '0) &&
          (map_d[com_dst_i[w*REG_SEL +: REG_SEL]] == com_renamed_i[w*RRF_SEL +: RRF_SEL]));
      for (int c = 0; c < CKPT_NUM; c++) begin
        snap_busy_d[c][com_dst_i[w*REG_SEL +: REG_SEL]] =
          snap_busy_d[c][com_dst_i[w*REG_SEL +: REG_SEL]] &
          ~(com_we_i[w] && (com_dst_i[w*REG_SEL +: REG_SEL] != '0) &&
            (snap_map_d[c][com_dst_i[w*REG_SEL +: REG_SEL]] ==
             com_renamed_i[w*RRF_SEL +: RRF_SEL]));
      end
    end

    // Ascending way order lets the higher way win an address collision
    for (int w = 0; w < WAY; w++) begin
      map_d[settag_addr_i[w*REG_SEL +: REG_SEL]] =
        (!restore_i && settag_we_i[w] && (settag_addr_i[w*REG_SEL +: REG_SEL] != '0)) ?
        settag_tag_i[w*RRF_SEL +: RRF_SEL] : map_d[settag_addr_i[w*REG_SEL +: REG_SEL]];
      busy_d[settag_addr_i[w*REG_SEL +: REG_SEL]] =
        busy_d[settag_addr_i[w*REG_SEL +: REG_SEL]] |
        (!restore_i && settag_we_i[w] && (settag_addr_i[w*REG_SEL +: REG_SEL] != '0));
    end

    if (restore_i) begin
      tail_d = head_q + PTR_W'(rel_s);
    end else if (take_s) begin
      tail_d                            = tail_q + PTR_W'(1);
      snap_map_d[tail_q[CKPT_SEL-1:0]]  = map_d;
      snap_busy_d[tail_q[CKPT_SEL-1:0]] = busy_d;
    end else begin
      tail_d = tail_q;
    end
    head_d = release_s ? (head_q + PTR_W'(1)) : head_q;
  end

  // Table, snapshot and pointer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      map_q       <= '0;
      busy_q      <= '0;
      snap_map_q  <= '0;
      snap_busy_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      map_q       <= map_d;
      busy_q      <= busy_d;
      snap_map_q  <= snap_map_d;
      snap_busy_q <= snap_busy_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  rename_table_ckpt_chk #(.CKPT_SEL(CKPT_SEL)) u_chk (
    .clk          (clk),
    .reset        (reset),
    .restore_i    (restore_i),
    .restore_id_i (restore_id_i),
    .head_i       (head_q),
    .tail_i       (tail_q)
  );
endmodule

// File: tb/tb_rename_table_ckpt.sv
// Bench for rename_table_ckpt: directed vector table, a mid-cycle reset
// sequence, then random traffic against a queue-based reference model.
module tb_rename_table_ckpt;
  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] rs_i;
  logic [23:0] rs_renamed_o;
  logic [3:0]  rs_busy_o;
  logic [1:0]  settag_we_i, com_we_i;
  logic [9:0]  settag_addr_i, com_dst_i;
  logic [11:0] settag_tag_i, com_renamed_i;
  logic        ckpt_take_i, ckpt_full_o, ckpt_empty_o, ckpt_release_i, restore_i;
  logic [1:0]  ckpt_id_o, restore_id_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rename_table_ckpt dut (
    .clk(clk), .reset(reset), .rs_i(rs_i), .rs_renamed_o(rs_renamed_o),
    .rs_busy_o(rs_busy_o), .settag_we_i(settag_we_i), .settag_addr_i(settag_addr_i),
    .settag_tag_i(settag_tag_i), .com_we_i(com_we_i), .com_dst_i(com_dst_i),
    .com_renamed_i(com_renamed_i), .ckpt_take_i(ckpt_take_i), .ckpt_id_o(ckpt_id_o),
    .ckpt_full_o(ckpt_full_o), .ckpt_empty_o(ckpt_empty_o),
    .ckpt_release_i(ckpt_release_i), .restore_i(restore_i), .restore_id_i(restore_id_i)
  );

  // stimulus, shared by the driver and the model
  int s_we [2], s_a [2], s_t [2], c_we [2], c_d [2], c_t [2], s_rs [4];
  int s_take, s_rel, s_rest, s_rid;

  // reference model: plain arrays plus an age-ordered queue of live slot ids
  int m_map [32];
  bit m_busy [32];
  int m_smap [4][32];
  bit m_sbusy [4][32];
  int m_q [$];
  int m_next;

  typedef struct packed {
    logic [1:0] we;  logic [4:0] a0;  logic [5:0] t0;  logic [4:0] a1;  logic [5:0] t1;
    logic [1:0] cwe; logic [4:0] cd0; logic [5:0] ct0; logic [4:0] cd1; logic [5:0] ct1;
    logic take; logic rel; logic rest; logic [1:0] rid; logic [4:0] probe;
    logic eb; logic [5:0] et; logic [1:0] eid; logic ef; logic ee;
  } vec_t;
  vec_t vecs [25];

  function automatic vec_t mk(int we, int a0, int t0, int a1, int t1,
                              int cwe, int cd0, int ct0, int cd1, int ct1,
                              int take, int rel, int rest, int rid, int probe,
                              int eb, int et, int eid, int ef, int ee);
    vec_t v;
    v.we = 2'(we);   v.a0 = 5'(a0);   v.t0 = 6'(t0);   v.a1 = 5'(a1);   v.t1 = 6'(t1);
    v.cwe = 2'(cwe); v.cd0 = 5'(cd0); v.ct0 = 6'(ct0); v.cd1 = 5'(cd1); v.ct1 = 6'(ct1);
    v.take = 1'(take); v.rel = 1'(rel); v.rest = 1'(rest); v.rid = 2'(rid);
    v.probe = 5'(probe); v.eb = 1'(eb); v.et = 6'(et); v.eid = 2'(eid);
    v.ef = 1'(ef); v.ee = 1'(ee);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int w = 0; w < 2; w++) begin
      s_we[w] = 0; s_a[w] = 0; s_t[w] = 0; c_we[w] = 0; c_d[w] = 0; c_t[w] = 0;
    end
    s_take = 0; s_rel = 0; s_rest = 0; s_rid = 0;
    for (int s = 0; s < 4; s++) s_rs[s] = 5;
  endtask

  task automatic apply();
    for (int w = 0; w < 2; w++) begin
      settag_we_i[w]          = (s_we[w] != 0);
      settag_addr_i[w*5 +: 5] = 5'(s_a[w]);
      settag_tag_i[w*6 +: 6]  = 6'(s_t[w]);
      com_we_i[w]             = (c_we[w] != 0);
      com_dst_i[w*5 +: 5]     = 5'(c_d[w]);
      com_renamed_i[w*6 +: 6] = 6'(c_t[w]);
    end
    for (int s = 0; s < 4; s++) rs_i[s*5 +: 5] = 5'(s_rs[s]);
    ckpt_take_i    = (s_take != 0);
    ckpt_release_i = (s_rel != 0);
    restore_i      = (s_rest != 0);
    restore_id_i   = 2'(s_rid);
  endtask

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) begin
      m_map[r] = 0; m_busy[r] = 1'b0;
      for (int c = 0; c < 4; c++) begin m_smap[c][r] = 0; m_sbusy[c][r] = 1'b0; end
    end
    m_q.delete();
    m_next = 0;
  endfunction

  task automatic m_check();
    int idx, eb, et;
    for (int s = 0; s < 4; s++) begin
      idx = s_rs[s];
      eb  = (idx != 0 && m_busy[idx]) ? 1 : 0;
      et  = (eb != 0) ? m_map[idx] : idx;
      check($sformatf("rnd_busy%0d", s), rs_busy_o[s], eb);
      check($sformatf("rnd_tag%0d", s), rs_renamed_o[s*6 +: 6], et);
    end
    check("rnd_id", ckpt_id_o, m_next);
    check("rnd_full", ckpt_full_o, (m_q.size() == 4) ? 1 : 0);
    check("rnd_empty", ckpt_empty_o, (m_q.size() == 0) ? 1 : 0);
  endtask

  function automatic void m_step();
    int k = -1;
    int pre = m_q.size();
    int d;
    if (s_rest != 0) begin
      foreach (m_q[i]) if (m_q[i] == s_rid && k < 0) k = i;
      for (int r = 0; r < 32; r++) begin
        m_map[r] = m_smap[s_rid][r]; m_busy[r] = m_sbusy[s_rid][r];
      end
    end
    for (int w = 0; w < 2; w++) begin
      d = c_d[w];
      if (c_we[w] != 0 && d != 0) begin
        if (m_busy[d] && m_map[d] == c_t[w]) m_busy[d] = 1'b0;
        foreach (m_q[i])
          if (m_sbusy[m_q[i]][d] && m_smap[m_q[i]][d] == c_t[w]) m_sbusy[m_q[i]][d] = 1'b0;
      end
    end
    if (s_rest == 0)
      for (int w = 0; w < 2; w++)
        if (s_we[w] != 0 && s_a[w] != 0) begin m_map[s_a[w]] = s_t[w]; m_busy[s_a[w]] = 1'b1; end
    if (s_rest != 0) begin
      while (m_q.size() > k) void'(m_q.pop_back());
      m_next = s_rid;
    end else if (s_take != 0 && pre < 4) begin
      for (int r = 0; r < 32; r++) begin
        m_smap[m_next][r] = m_map[r]; m_sbusy[m_next][r] = m_busy[r];
      end
      m_q.push_back(m_next);
      m_next = (m_next + 1) % 4;
    end
    if (s_rel != 0 && pre > 0) void'(m_q.pop_front());
  endfunction

  task automatic rand_stim();
    int k;
    for (int w = 0; w < 2; w++) begin
      s_we[w] = $urandom_range(0, 1); s_a[w] = $urandom_range(0, 7); s_t[w] = $urandom_range(0, 63);
      c_we[w] = $urandom_range(0, 1); c_d[w] = $urandom_range(0, 7);
      c_t[w]  = ($urandom_range(0, 1) != 0) ? m_map[c_d[w]] : $urandom_range(0, 63);
    end
    s_take = $urandom_range(0, 1);
    s_rel  = ($urandom_range(0, 3) == 0) ? 1 : 0;
    s_rest = 0; s_rid = 0;
    if (m_q.size() > 0 && $urandom_range(0, 7) == 0) begin
      k = $urandom_range(0, m_q.size() - 1);
      s_rest = 1; s_rid = m_q[k];
      if (k == 0) s_rel = 0;
    end
    for (int s = 0; s < 4; s++) s_rs[s] = $urandom_range(0, 7);
  endtask

  initial begin
    vecs[0]  = mk(0,0,0,0,0,    0,0,0,0,0,     0,0,0,0, 5, 0,5,0,0,1);
    vecs[1]  = mk(3,3,40,3,41,  0,0,0,0,0,     0,0,0,0, 3, 0,3,0,0,1);
    vecs[2]  = mk(0,0,0,0,0,    1,3,40,0,0,    0,0,0,0, 3, 1,41,0,0,1);
    vecs[3]  = mk(0,0,0,0,0,    2,0,0,3,41,    0,0,0,0, 3, 1,41,0,0,1);
    vecs[4]  = mk(0,0,0,0,0,    0,0,0,0,0,     0,0,0,0, 3, 0,3,0,0,1);
    vecs[5]  = mk(1,7,12,0,0,   0,0,0,0,0,     1,0,0,0, 7, 0,7,0,0,1);
    vecs[6]  = mk(1,7,20,0,0,   0,0,0,0,0,     0,0,0,0, 7, 1,12,1,0,0);
    vecs[7]  = mk(0,0,0,0,0,    0,0,0,0,0,     0,0,1,0, 7, 1,20,1,0,0);
    vecs[8]  = mk(0,0,0,0,0,    0,0,0,0,0,     1,0,0,0, 7, 1,12,0,0,1);
    vecs[9]  = mk(0,0,0,0,0,    0,0,0,0,0,     0,0,1,0, 7, 1,12,1,0,0);
    vecs[10] = mk(0,0,0,0,0,    0,0,0,0,0,     1,0,0,0, 3, 0,3,0,0,1);
    vecs[11] = mk(0,0,0,0,0,    0,0,0,0,0,     1,0,0,0, 3, 0,3,1,0,0);
    vecs[12] = mk(0,0,0,0,0,    0,0,0,0,0,     1,0,0,0, 3, 0,3,2,0,0);
    vecs[13] = mk(0,0,0,0,0,    0,0,0,0,0,     1,0,0,0, 3, 0,3,3,0,0);
    vecs[14] = mk(0,0,0,0,0,    0,0,0,0,0,     1,0,0,0, 3, 0,3,0,1,0);
    vecs[15] = mk(0,0,0,0,0,    0,0,0,0,0,     0,1,0,0, 3, 0,3,0,1,0);
    vecs[16] = mk(0,0,0,0,0,    0,0,0,0,0,     1,0,0,0, 3, 0,3,0,0,0);
    vecs[17] = mk(0,0,0,0,0,    0,0,0,0,0,     0,0,0,0, 3, 0,3,1,1,0);
    vecs[18] = mk(0,0,0,0,0,    0,0,0,0,0,     0,1,0,0, 3, 0,3,1,1,0);
    vecs[19] = mk(1,9,33,0,0,   0,0,0,0,0,     1,0,0,0, 9, 0,9,1,0,0);
    vecs[20] = mk(0,0,0,0,0,    1,9,33,0,0,    0,0,0,0, 9, 1,33,2,1,0);
    vecs[21] = mk(0,0,0,0,0,    0,0,0,0,0,     0,0,1,1, 9, 0,9,2,1,0);
    vecs[22] = mk(0,0,0,0,0,    0,0,0,0,0,     0,0,0,0, 9, 0,9,1,0,0);
    vecs[23] = mk(1,0,50,0,0,   0,0,0,0,0,     0,0,0,0, 0, 0,0,1,0,0);
    vecs[24] = mk(0,0,0,0,0,    0,0,0,0,0,     0,0,0,0, 0, 0,0,1,0,0);

    reset = 1'b0;
    clear_stim();
    apply();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    for (int s = 0; s < 4; s++) begin
      check($sformatf("rst_busy%0d", s), rs_busy_o[s], 0);
      check($sformatf("rst_tag%0d", s), rs_renamed_o[s*6 +: 6], 5);
    end
    check("rst_empty", ckpt_empty_o, 1);
    check("rst_full", ckpt_full_o, 0);
    check("rst_id", ckpt_id_o, 0);

    for (int i = 0; i < 25; i++) begin
      clear_stim();
      s_we[0] = vecs[i].we[0]; s_a[0] = vecs[i].a0; s_t[0] = vecs[i].t0;
      s_we[1] = vecs[i].we[1]; s_a[1] = vecs[i].a1; s_t[1] = vecs[i].t1;
      c_we[0] = vecs[i].cwe[0]; c_d[0] = vecs[i].cd0; c_t[0] = vecs[i].ct0;
      c_we[1] = vecs[i].cwe[1]; c_d[1] = vecs[i].cd1; c_t[1] = vecs[i].ct1;
      s_take = vecs[i].take; s_rel = vecs[i].rel; s_rest = vecs[i].rest; s_rid = vecs[i].rid;
      s_rs[0] = vecs[i].probe;
      apply();
      #1;
      check($sformatf("v%0d_busy", i), rs_busy_o[0], vecs[i].eb);
      check($sformatf("v%0d_tag", i), rs_renamed_o[5:0], vecs[i].et);
      check($sformatf("v%0d_id", i), ckpt_id_o, vecs[i].eid);
      check($sformatf("v%0d_full", i), ckpt_full_o, vecs[i].ef);
      check($sformatf("v%0d_empty", i), ckpt_empty_o, vecs[i].ee);
      @(posedge clk);
      @(negedge clk);
    end

    // asynchronous reset in the middle of a cycle with a take pending
    clear_stim();
    s_rs[0] = 7; s_take = 1; s_we[0] = 1; s_a[0] = 3; s_t[0] = 9;
    apply();
    #1;
    check("pre_rst_busy", rs_busy_o[0], 1);
    check("pre_rst_tag", rs_renamed_o[5:0], 12);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_empty", ckpt_empty_o, 1);
    check("mid_rst_full", ckpt_full_o, 0);
    check("mid_rst_id", ckpt_id_o, 0);
    check("mid_rst_busy", rs_busy_o[0], 0);
    check("mid_rst_tag", rs_renamed_o[5:0], 7);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    clear_stim();
    s_rs[0] = 3;
    apply();
    m_reset();
    #1;
    check("post_rst_empty", ckpt_empty_o, 1);
    check("post_rst_busy", rs_busy_o[0], 0);
    @(posedge clk);
    @(negedge clk);

    for (int n = 0; n < 400; n++) begin
      rand_stim();
      apply();
      #1;
      m_check();
      m_step();
      @(posedge clk);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
